life_ctrl: RTL
==============

LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 The module SHALL have these parameters, one per line: name, default, meaning.
- X, 8, board width in cells.
- Y, 8, board height in cells.
- LOG2X, 3, log2(X).
- LOG2Y, 3, log2(Y).
- PERIOD_W, 16, width of the auto-run period input.

REQ-002 The module SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- key_run, in, 1, debounced level; rising edge toggles run/pause.
- key_step, in, 1, debounced level; rising edge requests one generation.
- key_flip, in, 1, debounced edit key.
- key_up, in, 1, debounced edit key.
- key_down, in, 1, debounced edit key.
- key_left, in, 1, debounced edit key.
- key_right, in, 1, debounced edit key.
- period, in, PERIOD_W, idle cycles between auto-run generations.
- nxt_bit, out, 1, high while a generation is shifting.
- cnt, out, LOG2X+LOG2Y, cell index of the current shift cycle.
- gen_done, out, 1, one-cycle pulse after a generation completes.
- running, out, 1, auto-run mode flag.
- busy, out, 1, high in COMPUTE.
- edit_flip, out, 1, one-cycle gated edit pulse.
- edit_up, out, 1, one-cycle gated edit pulse.
- edit_down, out, 1, one-cycle gated edit pulse.
- edit_left, out, 1, one-cycle gated edit pulse.
- edit_right, out, 1, one-cycle gated edit pulse.
- gen_count, out, 16, completed-generation counter.

Function
REQ-003 Edge detection: each key SHALL have a registered previous value; edge = key & ~prev, evaluated each cycle.
REQ-004 States SHALL be IDLE, COMPUTE and WAIT; busy SHALL equal (state==COMPUTE); nxt_bit SHALL equal busy.
REQ-005 IDLE: on a key_step edge with running=0, the next state SHALL be COMPUTE with cnt=0.
REQ-006 IDLE: on a key_run edge, running SHALL toggle to 1 and the next state SHALL be COMPUTE with cnt=0.
REQ-007 When key_run and key_step edges coincide, the run edge SHALL take priority and the step edge SHALL be discarded.
REQ-008 COMPUTE SHALL last exactly X*Y cycles, with cnt = 0,1,...,X*Y-1 on successive cycles and no early exit.
REQ-009 On the cycle after cnt=X*Y-1:
- gen_done SHALL be 1 for exactly one cycle.
- gen_count SHALL increment, wrapping 0xFFFF->0.
- The state SHALL go to WAIT if running=1, else IDLE.
REQ-010 A key_run edge during COMPUTE SHALL toggle running immediately; the generation SHALL still complete, and the toggled value SHALL select the exit state.
REQ-011 WAIT SHALL last max(period,1) cycles, with period sampled on WAIT entry; the state SHALL then go to COMPUTE with cnt=0.
REQ-012 A key_run edge in WAIT SHALL clear running and go to IDLE on the next cycle.
REQ-013 key_step edges SHALL be ignored while running=1 or in COMPUTE; they SHALL NOT be queued.
REQ-014 edit_* SHALL be the corresponding key edge gated by (state!=COMPUTE), registered (1-cycle latency); edges during COMPUTE SHALL be dropped, never deferred.
REQ-015 cnt SHALL hold 0 outside COMPUTE.
REQ-016 Changes to period while in WAIT SHALL NOT affect the current wait.

Reset
REQ-017 While reset=0, asynchronously:
- state=IDLE.
- cnt=0, nxt_bit=0, busy=0, gen_done=0, running=0.
- edit_*=0, gen_count=0, wait timer=0.
- All key prev registers=1, so keys held through reset SHALL NOT produce edges.
REQ-018 Reset asserted mid-COMPUTE or mid-WAIT SHALL abort immediately; after release, the block SHALL be in IDLE with no pending step.

Verification
REQ-019 Single step: X=Y=8, key_step rises (sampled at edge k) -> nxt_bit=1 for cycles k+1..k+64, cnt 0..63, gen_done at k+65, gen_count=1, state IDLE.
REQ-020 Auto-run: key_run edge, period=5 -> running=1, COMPUTE 64 cycles, WAIT 5 cycles, repeating; gen_done pulses every 70 cycles.
REQ-021 period=0 while running -> WAIT lasts 1 cycle; gen_done spacing is 66 cycles.
REQ-022 Edit lockout: key_flip edge at cnt=10 -> no edit_flip; key_flip edge in IDLE -> edit_flip=1 for one cycle, one cycle later.
REQ-023 Pause in COMPUTE: key_run edge at cnt=30 while running -> running=0, generation finishes at cnt=63, then IDLE (no WAIT); gen_count increments.
REQ-024 Async reset at cnt=40 -> all outputs 0 immediately; key_step held high through reset release -> no generation starts until key_step falls and rises again.

Source files
------------

// File: rtl/life_ctrl_if.sv
// ---------------------------------------------------------------------------
// life_ctrl_if
//
// Purpose: bundles the key inputs, the auto-run period and every status or
// pulse output of the Game-of-Life sequencing controller, so the controller
// and whoever drives it share one connection.
//
// Signals:
//   key_run, key_step          debounced run/pause and single-step keys
//   key_flip/up/down/left/right debounced board-editing keys
//   period   [PERIOD_W]        idle cycles between auto-run generations
//   nxt_bit                    high while a generation is shifting
//   cnt      [LOG2X+LOG2Y]     cell index of the current shift cycle
//   gen_done                   one-cycle pulse after a generation completes
//   running                    auto-run mode flag
//   busy                       high while a generation is being computed
//   edit_*                     one-cycle, lockout-gated edit pulses
//   gen_count [16]             completed-generation counter
//
// Modports:
//   master  drives keys and period, observes the controller outputs
//   slave   the controller itself
// ---------------------------------------------------------------------------
interface life_ctrl_if #(
  parameter int LOG2X    = 3,
  parameter int LOG2Y    = 3,
  parameter int PERIOD_W = 16
);

  logic                     key_run;
  logic                     key_step;
  logic                     key_flip;
  logic                     key_up;
  logic                     key_down;
  logic                     key_left;
  logic                     key_right;
  logic [PERIOD_W-1:0]      period;

  logic                     nxt_bit;
  logic [LOG2X+LOG2Y-1:0]   cnt;
  logic                     gen_done;
  logic                     running;
  logic                     busy;
  logic                     edit_flip;
  logic                     edit_up;
  logic                     edit_down;
  logic                     edit_left;
  logic                     edit_right;
  logic [15:0]              gen_count;

  modport master (
    output key_run, key_step, key_flip, key_up, key_down, key_left, key_right,
    output period,
    input  nxt_bit, cnt, gen_done, running, busy,
    input  edit_flip, edit_up, edit_down, edit_left, edit_right,
    input  gen_count
  );

  modport slave (
    input  key_run, key_step, key_flip, key_up, key_down, key_left, key_right,
    input  period,
    output nxt_bit, cnt, gen_done, running, busy,
    output edit_flip, edit_up, edit_down, edit_left, edit_right,
    output gen_count
  );

endinterface

// File: rtl/life_ctrl.sv
// ---------------------------------------------------------------------------
// life_ctrl
//
// Purpose: sequencing controller for an X-by-Y Game-of-Life board. It turns
// debounced key levels into single-step or auto-run generations, sweeps a
// cell index across the whole board once per generation, counts completed
// generations and passes edit-key pulses through only while the board is
// not being recomputed.
//
// Ports:
//   clk     single clock, all state updates on the rising edge
//   reset   asynchronous, active-low reset
//   bus     life_ctrl_if.slave: keys and period in, status and pulses out
//
// Parameters:
//   X, Y       board width / height in cells
//   LOG2X/Y    log2 of X and Y (width of the cell index is their sum)
//   PERIOD_W   width of the auto-run period input
// ---------------------------------------------------------------------------
module life_ctrl #(
  parameter int X        = 8,
  parameter int Y        = 8,
  parameter int LOG2X    = 3,
  parameter int LOG2Y    = 3,
  parameter int PERIOD_W = 16
) (
  input logic        clk,
  input logic        reset,
  life_ctrl_if.slave bus
);

  localparam int            CW        = LOG2X + LOG2Y;
  localparam logic [CW-1:0] LAST_CELL = CW'(X * Y - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [PERIOD_W-1:0] r_waitTimer;
  logic                r_running;
  logic                r_busy;
  logic                r_genDone;
  logic [15:0]         r_genCount;

  logic                r_prevRun;
  logic                r_prevStep;
  logic [4:0]          r_prevEdit;
  logic [4:0]          r_editPulse;

  logic                w_runEdge;
  logic                w_stepEdge;
  logic [4:0]          w_editKeys;
  logic [4:0]          w_editEdge;
  logic                w_runAfterEdge;
  logic                w_lastCell;
  logic [PERIOD_W-1:0] w_waitLoad;

  // Edit keys packed flip, up, down, left, right (MSB to LSB).
  assign w_editKeys = {bus.key_flip, bus.key_up, bus.key_down,
                       bus.key_left, bus.key_right};

  // Rising-edge detection against the previous sampled key levels.
  assign w_runEdge  = bus.key_run  & ~r_prevRun;
  assign w_stepEdge = bus.key_step & ~r_prevStep;
  assign w_editEdge = w_editKeys   & ~r_prevEdit;

  // Run flag as it will be after this cycle; a run edge on the final shift
  // cycle must already steer the exit decision.
  assign w_runAfterEdge = r_running ^ w_runEdge;
  assign w_lastCell     = (r_cnt == LAST_CELL);

  // A zero period still yields a one-cycle wait.
  assign w_waitLoad = (bus.period == '0) ? PERIOD_W'(1) : bus.period;

  // Key history and edit pulses. The history resets to 1 so that a key held
  // down across reset release does not look like a fresh press. Edit edges
  // arriving while a generation is computing are dropped outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prevRun   <= 1'b1;
      r_prevStep  <= 1'b1;
      r_prevEdit  <= '1;
      r_editPulse <= '0;
    end else begin
      r_prevRun   <= bus.key_run;
      r_prevStep  <= bus.key_step;
      r_prevEdit  <= w_editKeys;
      r_editPulse <= w_editEdge & {5{r_state != S_COMPUTE}};
    end
  end

  // Main sequencer. IDLE waits for a run or step press, COMPUTE sweeps the
  // cell index over the whole board with no early exit, WAIT spaces auto-run
  // generations. The first WAIT cycle is the one carrying gen_done; the timer
  // loaded on entry (period sampled once, later changes ignored) then counts
  // max(period,1) further idle cycles before the next sweep. A run press in
  // WAIT pauses straight back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_waitTimer <= '0;
      r_running   <= 1'b0;
      r_busy      <= 1'b0;
      r_genDone   <= 1'b0;
      r_genCount  <= '0;
    end else begin
      r_genDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Run wins over a simultaneous step; the step is simply lost.
          if (w_runEdge) begin
            r_running <= 1'b1;
            r_state   <= S_COMPUTE;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
          end else if (w_stepEdge && !r_running) begin
            r_state <= S_COMPUTE;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end

        S_COMPUTE: begin
          if (w_runEdge) begin
            r_running <= ~r_running;
          end
          if (w_lastCell) begin
            r_genDone  <= 1'b1;
            r_genCount <= r_genCount + 16'd1;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            if (w_runAfterEdge) begin
              r_state     <= S_WAIT;
              r_waitTimer <= w_waitLoad;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_WAIT: begin
          if (w_runEdge) begin
            r_running   <= 1'b0;
            r_state     <= S_IDLE;
            r_waitTimer <= '0;
          end else if (r_waitTimer == '0) begin
            r_state <= S_COMPUTE;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_waitTimer <= r_waitTimer - PERIOD_W'(1);
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_waitTimer <= '0;
          r_running   <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.nxt_bit    = r_busy;
  assign bus.busy       = r_busy;
  assign bus.cnt        = r_cnt;
  assign bus.gen_done   = r_genDone;
  assign bus.running    = r_running;
  assign bus.gen_count  = r_genCount;
  assign bus.edit_flip  = r_editPulse[4];
  assign bus.edit_up    = r_editPulse[3];
  assign bus.edit_down  = r_editPulse[2];
  assign bus.edit_left  = r_editPulse[1];
  assign bus.edit_right = r_editPulse[0];

endmodule
